// File: rtl/bcd_sub_digit_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : bcd_sub_digit_sequencer
// Brief   : Digit-serial BCD subtractor (A-B, LSD first) that streams the raw
//           difference, its 10's complement and the sign to a magnitude mux.
// Revision: 1.0
// ============================================================================
module bcd_sub_digit_sequencer #(
    parameter int NDIG = 4,
    parameter int IW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NDIG-1:0]    a_bcd,
    input  logic [4*NDIG-1:0]    b_bcd,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    output logic [IW-1:0]        out_idx,
    output logic [3:0]           dig_raw,
    output logic [3:0]           dig_cmp,
    output logic                 sel_neg,
    output logic                 err
);

    localparam int              c_W    = 4 * NDIG;
    localparam logic [IW-1:0]   c_LAST = IW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Returns {borrow_out, digit} for a - b - bin with the BCD borrow rule.
    function automatic logic [4:0] f_dsub(input logic [3:0] a, input logic [3:0] b,
                                          input logic bin);
        logic [4:0] d;
        d = {1'b0, a} - {1'b0, b} - {4'd0, bin};
        if (d[4])
            f_dsub = {1'b1, d[3:0] + 4'd10};
        else
            f_dsub = {1'b0, d[3:0]};
    endfunction

    state_t             r_state;
    logic [c_W-1:0]     r_a;
    logic [c_W-1:0]     r_b;
    logic [c_W-1:0]     r_res;
    logic               r_bor;
    logic               r_cb;
    logic [IW-1:0]      r_cnt;

    logic               r_busy;
    logic               r_done;
    logic               r_out_valid;
    logic [IW-1:0]      r_out_idx;
    logic [3:0]         r_dig_raw;
    logic [3:0]         r_dig_cmp;
    logic               r_sel_neg;
    logic               r_err;

    logic               w_bad;
    logic [4:0]         w_sub;
    logic [c_W-1:0]     w_res_next;
    logic [c_W-1:0]     w_res_sh;
    logic [3:0]         w_cmp_src;
    logic               w_cmp_bin;
    logic [4:0]         w_cmp;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (a_bcd[4*i +: 4] > 4'd9 || b_bcd[4*i +: 4] > 4'd9)
                w_bad = 1'b1;
        end
    end

    // Result digits enter at the top so digit 0 ends up at the bottom after NDIG shifts.
    always_comb begin
        w_sub      = f_dsub(r_a[3:0], r_b[3:0], r_bor);
        w_res_sh   = r_res >> 4;
        w_res_next = w_res_sh | (c_W'(w_sub[3:0]) << (c_W - 4));
    end

    // The complement chain starts on the last SUB edge, with digit 0 still in flight.
    always_comb begin
        w_cmp_src = (r_state == S_SUB) ? w_res_next[3:0] : w_res_sh[3:0];
        w_cmp_bin = (r_state == S_SUB) ? 1'b0 : r_cb;
        w_cmp     = f_dsub(4'd0, w_cmp_src, w_cmp_bin);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_bor       <= 1'b0;
            r_cb        <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_dig_raw   <= 4'd0;
            r_dig_cmp   <= 4'd0;
            r_sel_neg   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a   <= a_bcd;
                        r_b   <= b_bcd;
                        r_bor <= 1'b0;
                        r_cnt <= '0;
                        if (w_bad) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_SUB;
                        end
                    end
                end
                S_SUB: begin
                    r_a   <= r_a >> 4;
                    r_b   <= r_b >> 4;
                    r_bor <= w_sub[4];
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state     <= S_OUT;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_idx   <= '0;
                        r_dig_raw   <= w_res_next[3:0];
                        r_dig_cmp   <= w_cmp[3:0];
                        r_cb        <= w_cmp[4];
                        r_sel_neg   <= w_sub[4];
                    end
                end
                S_OUT: begin
                    if (r_cnt == c_LAST) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_res     <= w_res_sh;
                        r_out_idx <= r_cnt + 1'b1;
                        r_dig_raw <= w_res_sh[3:0];
                        r_dig_cmp <= w_cmp[3:0];
                        r_cb      <= w_cmp[4];
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign dig_raw   = r_dig_raw;
    assign dig_cmp   = r_dig_cmp;
    assign sel_neg   = r_sel_neg;
    assign err       = r_err;

endmodule
`default_nettype wire
